misc_pipe: RTL and testbench



---
 rtl/misc_pkg.sv | 21 ++
 rtl/misc_pipe_if.sv | 29 ++
 rtl/misc_fifo.sv | 71 +++++++
 rtl/misc_pipe.sv | 161 ++++++++++++++++
 tb/tb_misc_pipe.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/misc_pkg.sv
// misc_pkg: mode encodings and sizing helpers shared by misc_pipe and misc_fifo.
`ifndef MISC_PKG_SV
`define MISC_PKG_SV

// Width of a packed {xout1, xout2} result; the struct is declared where NX is known.
`define MISC_RES_W(nx) (2 * (nx))

package misc_pkg;

    localparam logic [1:0] MODE_SUM     = 2'd0;
    localparam logic [1:0] MODE_DIFF    = 2'd1;
    localparam logic [1:0] MODE_BRANCHY = 2'd2;
    localparam logic [1:0] MODE_PROD    = 2'd3;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`endif

// File: rtl/misc_pipe_if.sv
// misc_pipe_if: operand/result handshake and accumulator bus of misc_pipe.
interface misc_pipe_if #(
    parameter int unsigned NX   = 8,
    parameter int unsigned ACCW = 12
);
    logic            IN_VALID;
    logic            IN_READY;
    logic [NX-1:0]   A;
    logic [NX-1:0]   B;
    logic [NX-1:0]   C;
    logic [1:0]      MODE;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [NX-1:0]   XOUT1;
    logic [NX-1:0]   XOUT2;
    logic            ACC_CLR;
    logic [ACCW-1:0] ACC;
    logic            ACC_OVF;

    modport master (
        output IN_VALID, A, B, C, MODE, OUT_READY, ACC_CLR,
        input  IN_READY, OUT_VALID, XOUT1, XOUT2, ACC, ACC_OVF
    );

    modport slave (
        input  IN_VALID, A, B, C, MODE, OUT_READY, ACC_CLR,
        output IN_READY, OUT_VALID, XOUT1, XOUT2, ACC, ACC_OVF
    );
endinterface

// File: rtl/misc_fifo.sv
// misc_fifo: synchronous FIFO with modulo-DEPTH pointers (any DEPTH) and async active-low reset.
module misc_fifo
    import misc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int unsigned   PW       = clog2_min1(DEPTH);
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = (wr_q == LAST) ? '0 : wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == LAST) ? '0 : rd_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end
endmodule

// File: rtl/misc_pipe.sv
// misc_pipe: two register stages computing XOUT1/XOUT2 into a credit-controlled result FIFO,
// plus a wrapping accumulator with sticky overflow over popped XOUT1 values.
module misc_pipe
    import misc_pkg::*;
#(
    parameter int unsigned NX    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ACCW  = 12
) (
    input logic        CLK,
    input logic        RST_N,
    misc_pipe_if.slave bus
);
    localparam int unsigned   RW      = `MISC_RES_W(NX);
    localparam int unsigned   UW      = $clog2(DEPTH + 1);
    localparam int unsigned   SW      = ACCW + 1;
    localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);

    typedef struct packed {
        logic [NX-1:0] xout1;
        logic [NX-1:0] xout2;
    } res_t;

    logic          accept;
    logic          pop;
    logic          out_valid;
    logic          fifo_full;
    logic          fifo_empty;
    res_t          head;

    logic          s1_v_q;
    logic [NX-1:0] s1_na_q,   s1_na_d;
    logic [NX-1:0] s1_nb_q,   s1_nb_d;
    logic          s1_gt_q,   s1_gt_d;
    logic [NX-1:0] s1_prod_q, s1_prod_d;
    logic [NX-1:0] s1_c5_q,   s1_c5_d;
    logic [1:0]    s1_mode_q;

    logic          s2_v_q;
    res_t          s2_res_q,  s2_res_d;

    logic [UW-1:0]   used_q, used_d;
    logic [ACCW-1:0] acc_q,  acc_d;
    logic            ovf_q,  ovf_d;
    logic [SW-1:0]   acc_sum;

    assign bus.IN_READY  = RST_N & (used_q < DEPTH_U);
    assign accept        = bus.IN_VALID & bus.IN_READY;
    assign out_valid     = ~fifo_empty;
    assign pop           = out_valid & bus.OUT_READY;
    assign bus.OUT_VALID = out_valid;
    assign bus.XOUT1     = head.xout1;
    assign bus.XOUT2     = head.xout2;
    assign bus.ACC       = acc_q;
    assign bus.ACC_OVF   = ovf_q;

    always_comb begin
        s1_na_d   = bus.A - bus.B;
        s1_nb_d   = bus.A + bus.B;
        s1_gt_d   = bus.A > bus.B;
        s1_prod_d = NX'(bus.A * bus.B);
        s1_c5_d   = bus.C + NX'(5);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_v_q    <= 1'b0;
            s1_na_q   <= '0;
            s1_nb_q   <= '0;
            s1_gt_q   <= 1'b0;
            s1_prod_q <= '0;
            s1_c5_q   <= '0;
            s1_mode_q <= '0;
        end else begin
            s1_v_q <= accept;
            if (accept) begin
                s1_na_q   <= s1_na_d;
                s1_nb_q   <= s1_nb_d;
                s1_gt_q   <= s1_gt_d;
                s1_prod_q <= s1_prod_d;
                s1_c5_q   <= s1_c5_d;
                s1_mode_q <= bus.MODE;
            end
        end
    end

    always_comb begin
        s2_res_d.xout1 = s1_nb_q;
        case (s1_mode_q)
            MODE_SUM:     s2_res_d.xout1 = s1_nb_q;
            MODE_DIFF:    s2_res_d.xout1 = s1_na_q;
            MODE_BRANCHY: s2_res_d.xout1 = s1_gt_q ? s1_nb_q : s1_na_q;
            MODE_PROD:    s2_res_d.xout1 = s1_prod_q;
            default:      s2_res_d.xout1 = s1_nb_q;
        endcase
        s2_res_d.xout2 = s1_na_q + s1_c5_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_v_q   <= 1'b0;
            s2_res_q <= '0;
        end else begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_res_q <= s2_res_d;
            end
        end
    end

    misc_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (s2_v_q),
        .data_i  (s2_res_q),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    // Credits cover both stages and the FIFO, so a push can never meet a full FIFO without a pop.
    assert property (@(posedge CLK) disable iff (!RST_N) !(s2_v_q && fifo_full && !pop));

    always_comb begin
        used_d = used_q;
        case ({accept, pop})
            2'b10:   used_d = used_q + UW'(1);
            2'b01:   used_d = used_q - UW'(1);
            default: used_d = used_q;
        endcase
    end

    always_comb begin
        acc_sum = {1'b0, acc_q} + SW'(head.xout1);
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (bus.ACC_CLR) begin
            acc_d = pop ? ACCW'(head.xout1) : '0;
            ovf_d = 1'b0;
        end else if (pop) begin
            acc_d = acc_sum[ACCW-1:0];
            ovf_d = ovf_q | acc_sum[ACCW];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            used_q <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            used_q <= used_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_misc_pipe.sv
// tb_misc_pipe: directed vectors into a scoreboard queue, checked by an independent output monitor.
module tb_misc_pipe;
    localparam int unsigned NX    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ACCW  = 12;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    misc_pipe_if #(.NX(NX), .ACCW(ACCW)) bus ();

    misc_pipe #(.NX(NX), .DEPTH(DEPTH), .ACCW(ACCW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] expq[$];
    int unsigned pops     = 0;
    int unsigned inflight = 0;
    logic [ACCW-1:0] acc_m = '0;
    logic            ovf_m = 1'b0;
    int unsigned     rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_x1(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        case (m)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return (a > b) ? a + b : a - b;
            default: return a * b;
        endcase
    endfunction

    function automatic logic [7:0] m_x2(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return a - b + c + 8'd5;
    endfunction

    // OUT_READY has a single writer; the main sequence only selects the mode.
    initial begin
        bus.OUT_READY = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            case (rdy_mode)
                0:       bus.OUT_READY = 1'b0;
                1:       bus.OUT_READY = 1'b1;
                default: bus.OUT_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: credit model, in-order result check, accumulator model.
    always @(negedge CLK) begin
        logic            p;
        logic [15:0]     e;
        logic [ACCW:0]   s;
        if (!RST_N) begin
            acc_m    = '0;
            ovf_m    = 1'b0;
            inflight = 0;
        end else begin
            chk("acc", bus.ACC, acc_m);
            chk("acc_ovf", bus.ACC_OVF, ovf_m);
            chk("in_ready_credit", bus.IN_READY, inflight < DEPTH);
            chk("used_bound", inflight <= DEPTH, 1);
            p = bus.OUT_VALID && bus.OUT_READY;
            e = '0;
            if (bus.OUT_VALID) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stale_output: got OUT_VALID=1 expected no result at %0t", $time);
                end else if (p) begin
                    e = expq.pop_front();
                    chk("xout1", bus.XOUT1, e[15:8]);
                    chk("xout2", bus.XOUT2, e[7:0]);
                    pops++;
                end
            end
            if (bus.ACC_CLR) begin
                acc_m = p ? ACCW'(e[15:8]) : '0;
                ovf_m = 1'b0;
            end else if (p) begin
                s     = {1'b0, acc_m} + (ACCW + 1)'(e[15:8]);
                acc_m = s[ACCW-1:0];
                ovf_m = ovf_m | s[ACCW];
            end
            if (bus.IN_VALID && bus.IN_READY) inflight++;
            if (p) inflight--;
        end
    end

    // Drives one triple, returns at posedge+1 after the accepting edge with IN_VALID still high.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [1:0] m, input logic [7:0] x1, input logic [7:0] x2);
        int unsigned n = 0;
        bus.A        = a;
        bus.B        = b;
        bus.C        = c;
        bus.MODE     = m;
        bus.IN_VALID = 1'b1;
        @(negedge CLK);
        while (!bus.IN_READY && n < 300) begin
            n++;
            @(negedge CLK);
        end
        if (!bus.IN_READY) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got IN_READY=0 expected 1 within 300 cycles");
        end else begin
            expq.push_back({x1, x2});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int unsigned n = 0;
        @(negedge CLK);
        while ((expq.size() != 0 || bus.OUT_VALID) && n < 500) begin
            n++;
            @(negedge CLK);
        end
        if (expq.size() != 0 || bus.OUT_VALID) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  va [6] = '{8'd200, 8'd100, 8'd127, 8'd127, 8'd127, 8'd5};
        logic [7:0]  vb [6] = '{8'd100, 8'd200, 8'd3,   8'd3,   8'd3,   8'd10};
        logic [1:0]  vm [6] = '{2'd2,   2'd2,   2'd0,   2'd1,   2'd3,   2'd1};
        logic [7:0]  vx1[6] = '{8'd44,  8'd156, 8'd130, 8'd124, 8'd125, 8'd251};
        logic [7:0]  vx2[6] = '{8'd108, 8'd164, 8'd132, 8'd132, 8'd132, 8'd3};
        int unsigned k;
        int unsigned pops0;
        int unsigned n;
        logic [7:0]  a, b, c;

        bus.IN_VALID = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.C        = '0;
        bus.MODE     = '0;
        bus.ACC_CLR  = 1'b0;
        RST_N        = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", bus.OUT_VALID, 0);
        chk("rst_in_ready", bus.IN_READY, 0);
        chk("rst_acc", bus.ACC, 0);
        chk("rst_acc_ovf", bus.ACC_OVF, 0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Directed vectors; first one also pins the 3-edge latency.
        rdy_mode = 1;
        send(va[0], vb[0], 8'd3, vm[0], vx1[0], vx2[0]);
        bus.IN_VALID = 1'b0;
        @(negedge CLK); chk("lat_edge_t", bus.OUT_VALID, 0);
        @(negedge CLK); chk("lat_edge_t1", bus.OUT_VALID, 0);
        @(negedge CLK); chk("lat_edge_t2", bus.OUT_VALID, 1);
        @(posedge CLK); #1;
        for (int i = 1; i < 6; i++) send(va[i], vb[i], 8'd3, vm[i], vx1[i], vx2[i]);
        bus.IN_VALID = 1'b0;
        drain();

        // Fill with OUT_READY low: IN_VALID held for 6 cycles, only DEPTH accepted.
        rdy_mode = 0;
        pops0    = pops;
        k        = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            a = 8'(10 + k * 20); b = 8'(k * 7); c = 8'(k);
            bus.A = a; bus.B = b; bus.C = c; bus.MODE = 2'(k);
            bus.IN_VALID = 1'b1;
            @(negedge CLK);
            if (bus.IN_READY) begin
                expq.push_back({m_x1(a, b, 2'(k)), m_x2(a, b, c)});
                k++;
            end
            @(posedge CLK);
            #1;
        end
        chk("fill_accepts", k, DEPTH);
        @(negedge CLK);
        chk("fill_in_ready_low", bus.IN_READY, 0);
        @(posedge CLK); #1;
        rdy_mode = 1;
        while (k < 6) begin
            a = 8'(10 + k * 20); b = 8'(k * 7); c = 8'(k);
            send(a, b, c, 2'(k), m_x1(a, b, 2'(k)), m_x2(a, b, c));
            k++;
        end
        bus.IN_VALID = 1'b0;
        drain();
        chk("fill_pop_count", pops - pops0, 6);

        // Back-to-back stream under random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 16; i++) begin
            a = 8'(i * 37 + 11); b = 8'(i * 91 + 200); c = 8'(i * 13);
            send(a, b, c, 2'(i), m_x1(a, b, 2'(i)), m_x2(a, b, c));
        end
        bus.IN_VALID = 1'b0;
        rdy_mode     = 1;
        drain();

        // Accumulator: clear while idle, then 17 x 255 = 4335 -> 239 with wrap.
        bus.ACC_CLR = 1'b1;
        @(posedge CLK); #1;
        bus.ACC_CLR = 1'b0;
        @(negedge CLK);
        chk("acc_clr_idle", bus.ACC, 0);
        @(posedge CLK); #1;
        for (int i = 0; i < 17; i++) send(8'd255, 8'd0, 8'd0, 2'd0, 8'd255, 8'd4);
        bus.IN_VALID = 1'b0;
        drain();
        @(negedge CLK);
        chk("acc_17x255", bus.ACC, 239);
        chk("acc_17x255_ovf", bus.ACC_OVF, 1);

        // ACC_CLR coincident with a pop of 7.
        @(posedge CLK); #1;
        rdy_mode = 0;
        send(8'd10, 8'd3, 8'd0, 2'd1, 8'd7, 8'd12);
        bus.IN_VALID = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!bus.OUT_VALID && n < 20) begin n++; @(negedge CLK); end
        chk("clrpop_ready_head", bus.OUT_VALID, 1);
        @(posedge CLK); #1;
        rdy_mode    = 1;
        bus.ACC_CLR = 1'b1;
        @(posedge CLK); #1;
        bus.ACC_CLR = 1'b0;
        @(negedge CLK);
        chk("acc_clr_pop", bus.ACC, 7);
        chk("acc_clr_pop_ovf", bus.ACC_OVF, 0);

        // Reset with 2 results in the FIFO and 2 in the stages.
        @(posedge CLK); #1;
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) send(8'(50 + i), 8'd1, 8'd0, 2'd0, 8'(51 + i), 8'(54 + i));
        bus.IN_VALID = 1'b0;
        chk("pre_rst_out_valid", bus.OUT_VALID, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_out_valid", bus.OUT_VALID, 0);
        chk("async_rst_in_ready", bus.IN_READY, 0);
        chk("async_rst_acc", bus.ACC, 0);
        expq.delete();
        @(posedge CLK); #2;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_in_ready", bus.IN_READY, 1);
        @(posedge CLK); #1;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("post_rst_no_stale", bus.OUT_VALID, 0);
        end
        @(posedge CLK); #1;
        send(8'd127, 8'd3, 8'd3, 2'd3, 8'd125, 8'd132);
        bus.IN_VALID = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
